mul1_shift_add: RTL and testbench

//  Sequential 8x8 unsigned shift-add multiplier with a 16-bit product; the "Alg1" datapath.

---
 rtl/mul1_shift_add.sv | 132 +++++++++++++
 tb/tb_mul1_shift_add.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul1_shift_add.sv
// mul1_shift_add: sequential 8x8 unsigned shift-add multiplier ("Alg1" datapath).
// An active-low load starts a multiply. Each clock the multiplicand shifts left,
// the multiplier shifts right, and the accumulator adds the multiplicand whenever
// the multiplier LSB is set. The product appears on result after 8 iterations.
// Optional feature macro: HEX_DISPLAY_EN adds four active-low seven-segment
// digit outputs (disp3 = most significant nibble) decoded from result.

`ifdef HEX_DISPLAY_EN
// Hex nibble to seven-segment code, {dp,g,f,e,d,c,b,a}, active-low, dp off.
module mul1_hex7seg (
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  // Combinational lookup of the digit pattern.
  always_comb begin
    // NOTE: a default before the case keeps this purely combinational (no latch).
    seg = 8'hFF;
    case (nib)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
      default: seg = 8'hFF;
    endcase
  end

endmodule
`endif

module mul1_shift_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  aIn,
  input  logic [7:0]  bIn,
  output logic [0:15] result,
`ifdef HEX_DISPLAY_EN
  output logic [7:0]  disp0,
  output logic [7:0]  disp1,
  output logic [7:0]  disp2,
  output logic [7:0]  disp3,
`endif
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] mcand;   // multiplicand, shifted left each step
  logic [7:0]  mplier;  // multiplier, shifted right each step
  logic [15:0] acc;     // running partial product
  logic [2:0]  cnt;     // iteration index 0..7
  logic [15:0] acc_step;

  // Accumulator value after this step's conditional add; 8x8 never overflows 16 bits.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  // Control FSM and datapath; result only moves on the completion edge.
  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!load) begin
            mcand  <= {8'b0, aIn};
            mplier <= bIn;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            result <= acc_step;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          // Holding load low here must not retrigger; a release returns to IDLE.
          if (load) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HEX_DISPLAY_EN
  // Displays follow result, so they show four "0" digits out of reset.
  mul1_hex7seg u_dig3 (.nib(result[0:3]),   .seg(disp3));
  mul1_hex7seg u_dig2 (.nib(result[4:7]),   .seg(disp2));
  mul1_hex7seg u_dig1 (.nib(result[8:11]),  .seg(disp1));
  mul1_hex7seg u_dig0 (.nib(result[12:15]), .seg(disp0));
`endif

endmodule

// File: tb/tb_mul1_shift_add.sv
// Self-checking bench for mul1_shift_add: table of directed products plus
// hand-written sequences for held load, mid-run operand changes, mid-run reset
// and (with HEX_DISPLAY_EN) the seven-segment decode table.
module tb_mul1_shift_add;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [7:0]  aIn;
  logic [7:0]  bIn;
  logic [0:15] result;
  logic        busy;
  logic        done;
  logic [15:0] prod;
`ifdef HEX_DISPLAY_EN
  logic [7:0]  disp0, disp1, disp2, disp3;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // result[0] is the MSB, so this maps it to a conventional [15:0] value.
  assign prod = result;

  mul1_shift_add dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .aIn    (aIn),
    .bIn    (bIn),
    .result (result),
`ifdef HEX_DISPLAY_EN
    .disp0  (disp0),
    .disp1  (disp1),
    .disp2  (disp2),
    .disp3  (disp3),
`endif
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a multiply from IDLE; reports edges until done (bounded).
  task automatic start_and_wait(input logic [7:0] a, input logic [7:0] b, output int edges);
    load = 1'b1;
    if (done) step();
    aIn  = a;
    bIn  = b;
    load = 1'b0;
    step();
    load = 1'b1;
    check("busy_after_start", busy, 1'b1);
    edges = 0;
    while (!done && edges < 20) begin
      step();
      edges++;
    end
  endtask

  task automatic mult(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] p);
    int edges;
    start_and_wait(a, b, edges);
    check({name, "_latency"}, edges, 8);
    check({name, "_busy_low"}, busy, 1'b0);
    check({name, "_result"}, prod, p);
  endtask

`ifdef HEX_DISPLAY_EN
  logic [7:0] seg_codes [16];
`endif

  initial begin
    int edges;
    int busy_cycles;
    int changes;
    logic [15:0] held;

    vecs[0] = '{8'd20,  8'd23,  16'h01CC};
    vecs[1] = '{8'd255, 8'd255, 16'hFE01};
    vecs[2] = '{8'd0,   8'd200, 16'h0000};
    vecs[3] = '{8'd1,   8'd1,   16'h0001};
    vecs[4] = '{8'd200, 8'd0,   16'h0000};
    vecs[5] = '{8'd128, 8'd2,   16'h0100};
    vecs[6] = '{8'd15,  8'd17,  16'h00FF};
    vecs[7] = '{8'd170, 8'd85,  16'h3872};
    vecs[8] = '{8'd1,   8'd255, 16'h00FF};
    vecs[9] = '{8'd13,  8'd11,  16'h008F};

    // Reset state.
    rst_n = 1'b0;
    load  = 1'b1;
    aIn   = 8'd0;
    bIn   = 8'd0;
    step();
    step();
    check("rst_result", prod, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
`ifdef HEX_DISPLAY_EN
    check("rst_disp", {disp3, disp2, disp1, disp0}, 32'hC0C0C0C0);
`endif
    rst_n = 1'b1;
    step();
    check("idle_no_start", busy, 1'b0);

    // Directed product table.
    for (int i = 0; i < 10; i++) begin
      mult($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
`ifdef HEX_DISPLAY_EN
      if (i == 0) check("vec0_disp", {disp3, disp2, disp1, disp0}, 32'hC0F9C6C6);
`endif
    end

    // Release load: done clears on the edge that returns to IDLE, result holds.
    load = 1'b1;
    step();
    check("release_done", done, 1'b0);
    check("release_hold", prod, 16'h008F);

    // Load held low for 25 cycles: exactly one multiply, done stays, result stable.
    aIn  = 8'd7;
    bIn  = 8'd9;
    load = 1'b0;
    busy_cycles = 0;
    changes = 0;
    held = prod;
    for (int c = 0; c < 25; c++) begin
      step();
      if (busy) busy_cycles++;
      if (prod != held) changes++;
      held = prod;
    end
    check("hold_busy_cycles", busy_cycles, 8);
    check("hold_changes", changes, 1);
    check("hold_done", done, 1'b1);
    check("hold_result", prod, 16'd63);
    load = 1'b1;
    step();
    check("hold_release_done", done, 1'b0);
    check("hold_release_result", prod, 16'd63);
    mult("after_hold", 8'd2, 8'd3, 16'd6);

    // Operands changed mid-run are ignored; result keeps the old product until done.
    load = 1'b1;
    step();
    aIn  = 8'd20;
    bIn  = 8'd23;
    load = 1'b0;
    step();
    load = 1'b1;
    for (int c = 0; c < 4; c++) step();
    aIn = 8'd255;
    bIn = 8'd255;
    check("midrun_busy", busy, 1'b1);
    check("midrun_old_result", prod, 16'd6);
    edges = 4;
    while (!done && edges < 20) begin
      step();
      if (!done) check("midrun_no_partial", prod, 16'd6);
      edges++;
    end
    check("midrun_latency", edges, 8);
    check("midrun_result", prod, 16'h01CC);

    // Reset in the middle of a run.
    load = 1'b1;
    step();
    aIn  = 8'd99;
    bIn  = 8'd77;
    load = 1'b0;
    step();
    load = 1'b1;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    check("midrst_result", prod, 16'h0000);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    rst_n = 1'b1;
    step();
    step();
    check("midrst_idle_busy", busy, 1'b0);
    check("midrst_idle_done", done, 1'b0);
    mult("after_rst", 8'd99, 8'd77, 16'h1DC7);

`ifdef HEX_DISPLAY_EN
    // Nibble sweep: a = n*17 (0xnn), b = 1 puts n in the two low digits.
    seg_codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    for (int n = 0; n < 16; n++) begin
      logic [7:0] a;
      a = 8'(n * 17);
      mult($sformatf("sweep%0d", n), a, 8'd1, {8'h00, a});
      check($sformatf("sweep%0d_disp", n), {disp3, disp2, disp1, disp0},
            {8'hC0, 8'hC0, seg_codes[n], seg_codes[n]});
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
